// File: rtl/tl_pkg.sv
// TileLink channel types, opcodes and params shared by the tile bus, L1 caches and memory responder.
package tl_pkg;

  localparam int TL_ADDR_WTH = 64;
  localparam int TL_DATA_WTH = 64;
  localparam int TL_MASK_WTH = TL_DATA_WTH / 8;
  localparam int TL_SIZE_WTH = 4;
  localparam int TL_SRC_WTH  = 8;
  localparam int TL_SINK_WTH = 4;

  // A channel opcodes
  localparam logic [2:0] A_PUT_FULL      = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL   = 3'd1;
  localparam logic [2:0] A_ARITHMETIC    = 3'd2;
  localparam logic [2:0] A_LOGICAL       = 3'd3;
  localparam logic [2:0] A_GET           = 3'd4;
  localparam logic [2:0] A_INTENT        = 3'd5;
  localparam logic [2:0] A_ACQUIRE_BLOCK = 3'd6;
  localparam logic [2:0] A_ACQUIRE_PERM  = 3'd7;

  // C channel opcodes
  localparam logic [2:0] C_PROBE_ACK      = 3'd4;
  localparam logic [2:0] C_PROBE_ACK_DATA = 3'd5;
  localparam logic [2:0] C_RELEASE        = 3'd6;
  localparam logic [2:0] C_RELEASE_DATA   = 3'd7;

  // D channel opcodes
  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;
  localparam logic [2:0] D_GRANT           = 3'd4;
  localparam logic [2:0] D_GRANT_DATA      = 3'd5;
  localparam logic [2:0] D_RELEASE_ACK     = 3'd6;

  // Cap params (D) and grow params (A)
  localparam logic [1:0] CAP_TO_T  = 2'd0;
  localparam logic [1:0] CAP_TO_B  = 2'd1;
  localparam logic [1:0] CAP_TO_N  = 2'd2;
  localparam logic [2:0] GROW_N_TO_B = 3'd0;
  localparam logic [2:0] GROW_N_TO_T = 3'd1;
  localparam logic [2:0] GROW_B_TO_T = 3'd2;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [2:0]             param;
    logic [TL_SIZE_WTH-1:0] size;
    logic [TL_SRC_WTH-1:0]  source;
    logic [TL_ADDR_WTH-1:0] address;
    logic [TL_MASK_WTH-1:0] mask;
    logic [TL_DATA_WTH-1:0] data;
  } A_chan_bits_t;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [1:0]             param;
    logic [TL_SIZE_WTH-1:0] size;
    logic [TL_SRC_WTH-1:0]  source;
    logic [TL_ADDR_WTH-1:0] address;
    logic [TL_MASK_WTH-1:0] mask;
    logic [TL_DATA_WTH-1:0] data;
  } B_chan_bits_t;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [2:0]             param;
    logic [TL_SIZE_WTH-1:0] size;
    logic [TL_SRC_WTH-1:0]  source;
    logic [TL_ADDR_WTH-1:0] address;
    logic [TL_DATA_WTH-1:0] data;
  } C_chan_bits_t;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [1:0]             param;
    logic [TL_SIZE_WTH-1:0] size;
    logic [TL_SRC_WTH-1:0]  source;
    logic [TL_SINK_WTH-1:0] sink;
    logic                   denied;
    logic [TL_DATA_WTH-1:0] data;
    logic                   corrupt;
  } D_chan_bits_t;

  typedef struct packed {
    logic [TL_SINK_WTH-1:0] sink;
  } E_chan_bits_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_ACK,
    ST_WAIT_E,
    ST_REL
  } rsp_state_t;

  // Index of the last beat of a 2^size transfer on a 2^beat_shift byte bus.
  function automatic logic [15:0] tl_beats_m1(input logic [TL_SIZE_WTH-1:0] size,
                                              input int beat_shift);
    logic [15:0] v;
    v = '0;
    if (int'(size) > beat_shift) v = (16'd1 << (int'(size) - beat_shift)) - 16'd1;
    return v;
  endfunction

endpackage

// File: rtl/sy_tl_sram.sv
// Single-port sync SRAM: 1-cycle read latency, read data held while i_re=0, per-byte write enables.
module sy_tl_sram #(
  parameter int DATA_WTH = 64,
  parameter int DEPTH    = 8192,
  localparam int BB      = DATA_WTH / 8,
  localparam int IDX_WTH = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                i_re,
  input  logic [BB-1:0]       i_we,
  input  logic [IDX_WTH-1:0]  i_idx,
  input  logic [DATA_WTH-1:0] i_wdata,
  output logic [DATA_WTH-1:0] o_rdata
);

  logic [DATA_WTH-1:0] r_mem [DEPTH];
  logic [DATA_WTH-1:0] r_rdata;

  // NOTE: the array has no reset branch; only the read register is reset, which keeps the store a plain SRAM.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < BB; b++) begin
      if (i_we[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sy_tl_mem_responder.sv
// TileLink manager backed by sy_tl_sram: Get/Put/Acquire/Release, one transaction in flight, no probes.
// Optional TL_RSP_ERR_CHK_EN: deny out-of-range addresses and unknown opcodes.
module sy_tl_mem_responder
  import tl_pkg::*;
#(
  parameter int                     ADDR_WTH  = 64,
  parameter int                     DATA_WTH  = 64,
  parameter int                     MEM_BYTES = 65536,
  parameter logic [ADDR_WTH-1:0]    BASE_ADDR = '0,
  parameter logic [TL_SINK_WTH-1:0] SINK_ID   = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         A_valid_i,
  output logic         A_ready_o,
  input  A_chan_bits_t A_bits_i,
  output logic         B_valid_o,
  input  logic         B_ready_i,
  output B_chan_bits_t B_bits_o,
  input  logic         C_valid_i,
  output logic         C_ready_o,
  input  C_chan_bits_t C_bits_i,
  output logic         D_valid_o,
  input  logic         D_ready_i,
  output D_chan_bits_t D_bits_o,
  input  logic         E_valid_i,
  output logic         E_ready_o,
  input  E_chan_bits_t E_bits_i
);

  localparam int BEAT_BYTES = DATA_WTH / 8;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int MEM_AW     = $clog2(MEM_BYTES);
  localparam int DEPTH      = MEM_BYTES / BEAT_BYTES;
  localparam int IDX_WTH    = MEM_AW - BEAT_SHIFT;

  rsp_state_t r_state, w_next_state;

  logic                   r_live;
  logic [15:0]            r_beat;
  logic [15:0]            r_last;
  logic [MEM_AW-1:0]      r_off;
  logic [2:0]             r_d_opcode;
  logic [TL_SIZE_WTH-1:0] r_size;
  logic [TL_SRC_WTH-1:0]  r_source;
  logic [TL_SINK_WTH-1:0] r_d_sink;
  logic                   r_denied;
  logic                   r_has_data;

  logic [ADDR_WTH-1:0]   w_a_aligned, w_c_aligned, w_a_off, w_c_off;
  logic [MEM_AW-1:0]     w_beat_off;
  logic [IDX_WTH-1:0]    w_a_idx, w_c_idx, w_beat_idx;
  logic [15:0]           w_a_last, w_c_last;
  logic                  w_a_err, w_c_err, w_a_grant, w_a_has_data;
  logic [2:0]            w_a_rsp_op;
  logic                  w_a_take, w_c_take, w_beat_adv;
  logic                  w_sram_re;
  logic [BEAT_BYTES-1:0] w_sram_we;
  logic [IDX_WTH-1:0]    w_sram_idx;
  logic [DATA_WTH-1:0]   w_sram_wdata, w_sram_rdata;
  logic                  w_unused;

  // Request decode: beat 0 is the aligned base; later beats step by BEAT_BYTES from it.
  assign w_a_aligned = A_bits_i.address & ~((ADDR_WTH'(1) << A_bits_i.size) - ADDR_WTH'(1));
  assign w_c_aligned = C_bits_i.address & ~((ADDR_WTH'(1) << C_bits_i.size) - ADDR_WTH'(1));
  assign w_a_off     = w_a_aligned - BASE_ADDR;
  assign w_c_off     = w_c_aligned - BASE_ADDR;
  assign w_a_idx     = w_a_off[MEM_AW-1:BEAT_SHIFT];
  assign w_c_idx     = w_c_off[MEM_AW-1:BEAT_SHIFT];
  assign w_beat_off  = r_off + (MEM_AW'(r_beat) << BEAT_SHIFT);
  assign w_beat_idx  = w_beat_off[MEM_AW-1:BEAT_SHIFT];
  assign w_a_last    = tl_beats_m1(A_bits_i.size, BEAT_SHIFT);
  assign w_c_last    = tl_beats_m1(C_bits_i.size, BEAT_SHIFT);

  assign w_a_grant    = (A_bits_i.opcode == A_ACQUIRE_BLOCK) || (A_bits_i.opcode == A_ACQUIRE_PERM);
  assign w_a_has_data = (A_bits_i.opcode == A_GET) || (A_bits_i.opcode == A_ACQUIRE_BLOCK);

  always_comb begin
    case (A_bits_i.opcode)
      A_GET:           w_a_rsp_op = D_ACCESS_ACK_DATA;
      A_ACQUIRE_BLOCK: w_a_rsp_op = D_GRANT_DATA;
      A_ACQUIRE_PERM:  w_a_rsp_op = D_GRANT;
      default:         w_a_rsp_op = D_ACCESS_ACK;
    endcase
  end

`ifdef TL_RSP_ERR_CHK_EN
  assign w_a_err = (|w_a_off[ADDR_WTH-1:MEM_AW]) ||
                   (A_bits_i.opcode == A_ARITHMETIC) || (A_bits_i.opcode == A_LOGICAL) ||
                   (A_bits_i.opcode == A_INTENT);
  assign w_c_err = (|w_c_off[ADDR_WTH-1:MEM_AW]) ||
                   !((C_bits_i.opcode == C_RELEASE) || (C_bits_i.opcode == C_RELEASE_DATA));
`else
  assign w_a_err = 1'b0;
  assign w_c_err = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_next_state = r_state;
    A_ready_o    = 1'b0;
    C_ready_o    = 1'b0;
    D_valid_o    = 1'b0;
    w_a_take     = 1'b0;
    w_c_take     = 1'b0;
    w_beat_adv   = 1'b0;
    w_sram_re    = 1'b0;
    w_sram_we    = '0;
    w_sram_idx   = w_beat_idx;
    w_sram_wdata = A_bits_i.data;

    case (r_state)
      ST_IDLE: begin
        if (r_live) begin
          C_ready_o = 1'b1;
          A_ready_o = ~C_valid_i;
          if (C_valid_i) begin
            w_c_take = 1'b1;
            w_next_state = ST_ACK;
            if (C_bits_i.opcode == C_RELEASE_DATA) begin
              w_sram_idx   = w_c_idx;
              w_sram_wdata = C_bits_i.data;
              w_sram_we    = w_c_err ? '0 : '1;
              if (w_c_last != 16'd0) w_next_state = ST_REL;
            end
          end else if (A_valid_i) begin
            w_a_take = 1'b1;
            case (A_bits_i.opcode)
              A_GET, A_ACQUIRE_BLOCK: begin
                w_sram_re    = 1'b1;
                w_sram_idx   = w_a_idx;
                w_next_state = ST_RD;
              end
              A_PUT_FULL, A_PUT_PARTIAL: begin
                w_sram_idx   = w_a_idx;
                w_sram_we    = w_a_err ? '0 : A_bits_i.mask;
                w_next_state = (w_a_last == 16'd0) ? ST_ACK : ST_WR;
              end
              default: w_next_state = ST_ACK;
            endcase
          end
        end
      end
      ST_RD: begin
        D_valid_o = 1'b1;
        if (D_ready_i) begin
          if (r_beat > r_last) begin
            w_next_state = (r_d_opcode == D_GRANT_DATA) ? ST_WAIT_E : ST_IDLE;
          end else begin
            w_sram_re  = 1'b1;
            w_beat_adv = 1'b1;
          end
        end
      end
      ST_WR: begin
        A_ready_o = 1'b1;
        if (A_valid_i) begin
          w_sram_we  = r_denied ? '0 : A_bits_i.mask;
          w_beat_adv = 1'b1;
          if (r_beat == r_last) w_next_state = ST_ACK;
        end
      end
      ST_REL: begin
        C_ready_o = 1'b1;
        if (C_valid_i) begin
          w_sram_wdata = C_bits_i.data;
          w_sram_we    = r_denied ? '0 : '1;
          w_beat_adv   = 1'b1;
          if (r_beat == r_last) w_next_state = ST_ACK;
        end
      end
      ST_ACK: begin
        D_valid_o = 1'b1;
        if (D_ready_i) w_next_state = (r_d_opcode == D_GRANT) ? ST_WAIT_E : ST_IDLE;
      end
      ST_WAIT_E: begin
        if (E_valid_i && (E_bits_i.sink == SINK_ID)) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // r_beat is the next beat to touch in the SRAM; beat 0 is handled in the IDLE handshake.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_live     <= 1'b0;
      r_beat     <= '0;
      r_last     <= '0;
      r_off      <= '0;
      r_d_opcode <= '0;
      r_size     <= '0;
      r_source   <= '0;
      r_d_sink   <= '0;
      r_denied   <= 1'b0;
      r_has_data <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_a_take) begin
        r_beat     <= 16'd1;
        r_last     <= w_a_last;
        r_off      <= w_a_off[MEM_AW-1:0];
        r_d_opcode <= w_a_rsp_op;
        r_size     <= A_bits_i.size;
        r_source   <= A_bits_i.source;
        r_d_sink   <= w_a_grant ? SINK_ID : '0;
        r_denied   <= w_a_err;
        r_has_data <= w_a_has_data;
      end else if (w_c_take) begin
        r_beat     <= 16'd1;
        r_last     <= w_c_last;
        r_off      <= w_c_off[MEM_AW-1:0];
        r_d_opcode <= D_RELEASE_ACK;
        r_size     <= C_bits_i.size;
        r_source   <= C_bits_i.source;
        r_d_sink   <= '0;
        r_denied   <= w_c_err;
        r_has_data <= 1'b0;
      end else if (w_beat_adv) begin
        r_beat <= r_beat + 16'd1;
      end
    end
  end

  sy_tl_sram #(
    .DATA_WTH (DATA_WTH),
    .DEPTH    (DEPTH)
  ) u_sram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_re    (w_sram_re),
    .i_we    (w_sram_we),
    .i_idx   (w_sram_idx),
    .i_wdata (w_sram_wdata),
    .o_rdata (w_sram_rdata)
  );

  // D fields come straight from registers and the held SRAM output, so they are stable on stalls.
  always_comb begin
    D_bits_o = '0;
    if (D_valid_o) begin
      D_bits_o.opcode  = r_d_opcode;
      D_bits_o.param   = CAP_TO_T;
      D_bits_o.size    = r_size;
      D_bits_o.source  = r_source;
      D_bits_o.sink    = r_d_sink;
      D_bits_o.denied  = r_denied;
      D_bits_o.corrupt = r_denied & r_has_data;
      D_bits_o.data    = (r_has_data && !r_denied) ? w_sram_rdata : '0;
    end
  end

  assign B_valid_o = 1'b0;
  assign B_bits_o  = '0;
  assign E_ready_o = r_live;

  assign w_unused = ^{B_ready_i, A_bits_i.param, C_bits_i.param,
                      w_a_off[ADDR_WTH-1:MEM_AW], w_a_off[BEAT_SHIFT-1:0],
                      w_c_off[ADDR_WTH-1:MEM_AW], w_c_off[BEAT_SHIFT-1:0],
                      w_beat_off[BEAT_SHIFT-1:0]};

endmodule
